// File: rtl/fixed_mac_accum.sv
// fixed_mac_accum
//   Streaming accumulator that sits after a 32-bit signed Q16.16 multiplier.
//   Products are summed per packet in a wide signed accumulator. A packet closes
//   on prod_last_in or after MAX_TERMS products. One saturated Q16.16 result per
//   packet is then offered over a valid/ready handshake.
//
// Parameters
//   ACC_WIDTH  accumulator width (signed, Q(ACC_WIDTH-16).16), must be >= 33
//   MAX_TERMS  maximum products per packet (forced close at this count)
//   CW         width of terms_out, derived from MAX_TERMS
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous reset, active high
//   prod_in         signed Q16.16 product
//   prod_valid_in   prod_in valid
//   prod_last_in    prod_in is the final term of the packet
//   prod_ready_out  product can be accepted this cycle (combinational)
//   sum_out         saturated signed Q16.16 packet sum
//   sum_valid_out   sum_out / sat_out / terms_out valid
//   sum_ready_in    consumer accepts the result
//   sat_out         result clipped to 32 bits or accumulator clamped in packet
//   terms_out       number of products in the packet
module fixed_mac_accum #(
  parameter int ACC_WIDTH = 40,
  parameter int MAX_TERMS = 256,
  parameter int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [31:0]   prod_in,
  input  logic          prod_valid_in,
  input  logic          prod_last_in,
  output logic          prod_ready_out,
  output logic [31:0]   sum_out,
  output logic          sum_valid_out,
  input  logic          sum_ready_in,
  output logic          sat_out,
  output logic [CW-1:0] terms_out
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]               count;
  logic                        sticky;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH:0]   sum_wide;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic [CW-1:0]               count_nxt;
  logic                        sticky_nxt;
  logic                        beat;
  logic                        close;

  // The one-bit-wider sum overflows the accumulator range exactly when its
  // top two bits disagree.
  function automatic logic acc_overflow(input logic signed [ACC_WIDTH:0] s);
    return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] clamp_acc(input logic signed [ACC_WIDTH:0] s);
    if (s[ACC_WIDTH] ^ s[ACC_WIDTH-1]) begin
      if (s[ACC_WIDTH])
        return {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
        return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return s[ACC_WIDTH-1:0];
  endfunction

  // Value fits Q16.16 when every bit from 31 upward equals the sign.
  function automatic logic fits_q16(input logic signed [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-32:0] hi;
    hi = v[ACC_WIDTH-1:31];
    return (&hi) | (~|hi);
  endfunction

  function automatic logic [31:0] sat_q16(input logic signed [ACC_WIDTH-1:0] v);
    if (fits_q16(v))
      return v[31:0];
    else if (v[ACC_WIDTH-1])
      return 32'h8000_0000;
    else
      return 32'h7FFF_FFFF;
  endfunction

  assign prod_ready_out = (state != DONE) && !rst_in;

  always_comb begin
    beat     = prod_valid_in && prod_ready_out;
    prod_ext = {{(ACC_WIDTH-32){prod_in[31]}}, prod_in};
    sum_wide = {acc[ACC_WIDTH-1], acc} + {prod_ext[ACC_WIDTH-1], prod_ext};
    if (state == IDLE) begin
      // First term of a packet: nothing to add to, so no clamp possible.
      acc_nxt    = prod_ext;
      count_nxt  = CW'(1);
      sticky_nxt = 1'b0;
    end else begin
      acc_nxt    = clamp_acc(sum_wide);
      count_nxt  = count + CW'(1);
      sticky_nxt = sticky | acc_overflow(sum_wide);
    end
    close = prod_last_in || (count_nxt == CW'(MAX_TERMS));
  end

  // Accumulate stage: packet state and registered result
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      acc           <= '0;
      count         <= '0;
      sticky        <= 1'b0;
      sum_out       <= '0;
      sum_valid_out <= 1'b0;
      sat_out       <= 1'b0;
      terms_out     <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            acc    <= acc_nxt;
            count  <= count_nxt;
            sticky <= sticky_nxt;
            if (close) begin
              state         <= DONE;
              sum_valid_out <= 1'b1;
              sum_out       <= sat_q16(acc_nxt);
              sat_out       <= sticky_nxt | !fits_q16(acc_nxt);
              terms_out     <= count_nxt;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          // No same-cycle accept: the product side reopens one cycle after
          // the result handshake.
          if (sum_ready_in) begin
            state         <= IDLE;
            sum_valid_out <= 1'b0;
            acc           <= '0;
            count         <= '0;
            sticky        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_mac_accum.sv
module tb_fixed_mac_accum;

  localparam int ACC_W = 33;
  localparam int MAX_T = 4;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W - 1));

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic [31:0]   prod_in = '0;
  logic          prod_valid_in = 1'b0;
  logic          prod_last_in = 1'b0;
  logic          prod_ready_out;
  logic [31:0]   sum_out;
  logic          sum_valid_out;
  logic          sum_ready_in = 1'b0;
  logic          sat_out;
  logic [CW-1:0] terms_out;

  fixed_mac_accum #(.ACC_WIDTH(ACC_W), .MAX_TERMS(MAX_T)) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .prod_in        (prod_in),
    .prod_valid_in  (prod_valid_in),
    .prod_last_in   (prod_last_in),
    .prod_ready_out (prod_ready_out),
    .sum_out        (sum_out),
    .sum_valid_out  (sum_valid_out),
    .sum_ready_in   (sum_ready_in),
    .sat_out        (sat_out),
    .terms_out      (terms_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        sat;
    int          terms;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     bp_mode = 0;   // 0 random backpressure, 1 hold low, 2 hold high
  bit     hs_prev = 1'b0;

  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_sticky = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on whole packets.
  task automatic model_beat(input logic [31:0] p, input logic last, output bit closed);
    longint v;
    exp_t   e;
    v = longint'($signed(p));
    if (m_cnt == 0) begin
      m_acc    = v;
      m_sticky = 1'b0;
    end else begin
      m_acc = m_acc + v;
      if (m_acc > AMAX) begin
        m_acc = AMAX;  m_sticky = 1'b1;
      end else if (m_acc < AMIN) begin
        m_acc = AMIN;  m_sticky = 1'b1;
      end
    end
    m_cnt++;
    closed = last || (m_cnt == MAX_T);
    if (closed) begin
      e.terms = m_cnt;
      e.sat   = m_sticky;
      if (m_acc > 64'sd2147483647) begin
        e.sum = 32'h7FFF_FFFF;  e.sat = 1'b1;
      end else if (m_acc < -64'sd2147483648) begin
        e.sum = 32'h8000_0000;  e.sat = 1'b1;
      end else begin
        e.sum = 32'(m_acc);
      end
      exp_q.push_back(e);
      m_cnt = 0;
    end
  endtask

  // All driver tasks start and end at posedge + 1.
  task automatic send(input logic [31:0] p, input logic last);
    int  waitc;
    bit  closed;
    waitc = 0;
    prod_in = p;  prod_last_in = last;  prod_valid_in = 1'b1;
    @(negedge clk);
    while (!prod_ready_out) begin
      waitc++;
      if (waitc > 200) begin
        n_cmp++;  n_bad++;
        $display("FAIL send_timeout: prod_ready_out stuck at %0b, required 1", prod_ready_out);
        prod_valid_in = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
    end
    model_beat(p, last, closed);
    @(posedge clk); #1;
    prod_valid_in = 1'b0;  prod_last_in = 1'b0;
    if (closed) check("latency_valid", {63'b0, sum_valid_out}, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      prod_valid_in = 1'b0;
      prod_in       = $urandom;
      prod_last_in  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    prod_last_in = 1'b0;
  endtask

  task automatic drain();
    int waitc;
    waitc = 0;
    bp_mode = 2;
    while ((exp_q.size() != 0 || sum_valid_out) && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (waitc >= 200) begin
      n_cmp++;  n_bad++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    m_cnt  = 0;
    @(negedge clk);
    check("rst_prod_ready", {63'b0, prod_ready_out}, 64'd0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(negedge clk);
    check("rst_sum_valid", {63'b0, sum_valid_out}, 64'd0);
    check("rst_sum_out", {32'b0, sum_out}, 64'd0);
    check("rst_terms", {{(64-CW){1'b0}}, terms_out}, 64'd0);
    check("rst_ready_after", {63'b0, prod_ready_out}, 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      1:       return $urandom;
      2:       return 32'($signed($urandom_range(0, 32'h0003_FFFF)) - 32'sh0002_0000);
      3:       return {($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 30'($urandom)};
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  // Backpressure driver, offset from the data driver to avoid races.
  always begin
    @(posedge clk); #2;
    case (bp_mode)
      0:       sum_ready_in = ($urandom_range(0, 3) != 0);
      1:       sum_ready_in = 1'b0;
      default: sum_ready_in = 1'b1;
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (hs_prev && !rst_in) begin
      check("bubble_valid", {63'b0, sum_valid_out}, 64'd0);
      check("bubble_ready", {63'b0, prod_ready_out}, 64'd1);
    end
    hs_prev = 1'b0;
    if (!rst_in && sum_valid_out && sum_ready_in) begin
      hs_prev = 1'b1;
      if (exp_q.size() == 0) begin
        n_cmp++;  n_bad++;
        $display("FAIL unexpected_result: sum_out %0h with no packet outstanding", sum_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum_out", {32'b0, sum_out}, {32'b0, mon_e.sum});
        check("sat_out", {63'b0, sat_out}, {63'b0, mon_e.sat});
        check("terms_out", {{(64-CW){1'b0}}, terms_out}, 64'(mon_e.terms));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_sum_valid", {63'b0, sum_valid_out}, 64'd0);
    check("reset_sum_out", {32'b0, sum_out}, 64'd0);
    check("reset_sat", {63'b0, sat_out}, 64'd0);
    check("reset_terms", {{(64-CW){1'b0}}, terms_out}, 64'd0);
    check("reset_prod_ready", {63'b0, prod_ready_out}, 64'd0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {63'b0, prod_ready_out}, 64'd1);
    @(posedge clk); #1;

    // Basic sum, positive clip, negative clip
    send(32'h0001_0000, 1'b0);
    send(32'h0002_0000, 1'b0);
    send(32'hFFFF_0000, 1'b1);
    send(32'h7FFF_0000, 1'b0);
    send(32'h7FFF_0000, 1'b1);
    send(32'h8000_0000, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    drain();

    // Result held under backpressure, then one-cycle bubble
    bp_mode = 1;
    send(32'h0005_0000, 1'b0);
    send(32'h0001_0000, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", {63'b0, sum_valid_out}, 64'd1);
      check("hold_prod_ready", {63'b0, prod_ready_out}, 64'd0);
      check("hold_sum", {32'b0, sum_out}, {32'b0, exp_q[$].sum});
      check("hold_terms", {{(64-CW){1'b0}}, terms_out}, 64'(exp_q[$].terms));
    end
    @(posedge clk); #1;
    bp_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("after_hs_ready", {63'b0, prod_ready_out}, 64'd1);
    @(posedge clk); #1;
    bp_mode = 0;

    // Force-close at MAX_TERMS, then a new packet; redundant last on closing beat
    repeat (4) send(32'h0000_0001, 1'b0);
    send(32'h0000_0007, 1'b1);
    repeat (3) send(32'h0000_0001, 1'b0);
    send(32'h0000_0002, 1'b1);
    // Accumulator clamp
    repeat (3) send(32'h8000_0000, 1'b0);
    send(32'h7FFF_FFFF, 1'b1);
    drain();

    // Reset mid-packet discards the partial sum
    bp_mode = 0;
    send(32'h0001_0000, 1'b0);
    send(32'h0001_0000, 1'b0);
    pulse_reset();
    send(32'h0003_0000, 1'b1);
    drain();

    // Reset while a result waits in DONE discards it
    bp_mode = 1;
    send(32'h0001_2345, 1'b1);
    idle(2);
    pulse_reset();
    void'(exp_q.pop_back());
    bp_mode = 0;

    // Randomized packets
    for (int pk = 0; pk < 150; pk++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        send(rand_val(), (i == len - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
